// File: rtl/readout_fsm.sv
// readout_fsm
//   Readout sequencer downstream of the exposure state machine. It takes the
//   end-of-exposure handshake, walks every pixel row (row select, settle,
//   ADC conversion, column streaming with a valid/ready output), and then
//   hands control back to exposure.
//
// Ports
//   CLKMPRE      sole clock, rising edge
//   RESET        synchronous active-high reset
//   FSMIND1      in : exposure done / readout requested (level)
//   FSMIND1ACK   out: acknowledge of FSMIND1
//   FSMIND0      out: readout done (level, held until FSMIND0ACK)
//   FSMIND0ACK   in : acknowledge of FSMIND0
//   ROW_ADDR     out: row being read
//   ROW_SEL      out: row select to the pixel array
//   ADC_START    out: one-cycle conversion start pulse
//   COL_ADDR     out: column mux select; ADC_DATA follows it combinationally
//   ADC_DATA     in : converted word for COL_ADDR
//   DOUT         out: output word
//   DOUT_VALID   out: DOUT holds a word
//   DOUT_READY   in : downstream accepts DOUT when high with DOUT_VALID
//   DOUT_LAST    out: marks the final word of the frame
//   fsm_stat     out: one-hot state code
//   CntFrame     out: frames completed since reset (wraps)
module readout_fsm #(
  parameter int C_NUM_ROWS   = 176,
  parameter int C_NUM_COLS   = 244,
  parameter int C_ADC_W      = 12,
  parameter int C_ROW_SETTLE = 4,
  parameter int C_ADC_CYCLES = 32
) (
  input  logic               CLKMPRE,
  input  logic               RESET,
  input  logic               FSMIND1,
  output logic               FSMIND1ACK,
  output logic               FSMIND0,
  input  logic               FSMIND0ACK,
  output logic [7:0]         ROW_ADDR,
  output logic               ROW_SEL,
  output logic               ADC_START,
  output logic [15:0]        COL_ADDR,
  input  logic [C_ADC_W-1:0] ADC_DATA,
  output logic [C_ADC_W-1:0] DOUT,
  output logic               DOUT_VALID,
  input  logic               DOUT_READY,
  output logic               DOUT_LAST,
  output logic [8:1]         fsm_stat,
  output logic [31:0]        CntFrame
);

  // State encodings double as the externally visible status code.
  typedef enum logic [7:0] {
    S_IDLE    = 8'h01,
    S_ACK1    = 8'h02,
    S_ROWSEL  = 8'h04,
    S_CONV    = 8'h08,
    S_READ    = 8'h10,
    S_ROWNEXT = 8'h20,
    S_DONE    = 8'h40
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(C_ROW_SETTLE - 1);
  localparam logic [15:0] CONV_LAST   = 16'(C_ADC_CYCLES - 1);
  localparam logic [15:0] NUM_COLS    = 16'(C_NUM_COLS);
  localparam logic [15:0] LAST_COL    = 16'(C_NUM_COLS - 1);
  localparam logic [7:0]  LAST_ROW    = 8'(C_NUM_ROWS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        advance;

  assign fsm_stat = state;

  // The output register can take a new word when empty or being drained.
  assign advance = !DOUT_VALID || DOUT_READY;

  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      FSMIND1ACK <= 1'b0;
      FSMIND0    <= 1'b0;
      ROW_ADDR   <= '0;
      ROW_SEL    <= 1'b0;
      ADC_START  <= 1'b0;
      COL_ADDR   <= '0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      DOUT_LAST  <= 1'b0;
      CntFrame   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (FSMIND1) begin
            FSMIND1ACK <= 1'b1;
            state      <= S_ACK1;
          end
        end

        S_ACK1: begin
          if (!FSMIND1) begin
            FSMIND1ACK <= 1'b0;
            ROW_ADDR   <= '0;
            state      <= S_ROWSEL;
          end
        end

        // ROW_SEL is raised on the first cycle here; the settle counter only
        // starts once ROW_SEL is actually high, so ADC_START lands exactly
        // C_ROW_SETTLE cycles after the rise regardless of how we entered.
        S_ROWSEL: begin
          if (!ROW_SEL) begin
            ROW_SEL <= 1'b1;
            cnt     <= '0;
          end else if (cnt == SETTLE_LAST) begin
            ADC_START <= 1'b1;
            cnt       <= '0;
            state     <= S_CONV;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_CONV: begin
          ADC_START <= 1'b0;
          if (cnt == CONV_LAST) begin
            COL_ADDR <= '0;
            cnt      <= '0;
            state    <= S_READ;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // COL_ADDR counts words loaded; once it reaches C_NUM_COLS the row is
        // fully loaded and the next advance means the last word was taken.
        S_READ: begin
          if (advance) begin
            if (COL_ADDR < NUM_COLS) begin
              DOUT       <= ADC_DATA;
              DOUT_VALID <= 1'b1;
              DOUT_LAST  <= (COL_ADDR == LAST_COL) && (ROW_ADDR == LAST_ROW);
              COL_ADDR   <= COL_ADDR + 16'd1;
            end else begin
              DOUT_VALID <= 1'b0;
              DOUT_LAST  <= 1'b0;
              state      <= S_ROWNEXT;
            end
          end
        end

        S_ROWNEXT: begin
          ROW_SEL <= 1'b0;
          if (ROW_ADDR < LAST_ROW) begin
            ROW_ADDR <= ROW_ADDR + 8'd1;
            state    <= S_ROWSEL;
          end else begin
            FSMIND0  <= 1'b1;
            CntFrame <= CntFrame + 32'd1;
            state    <= S_DONE;
          end
        end

        S_DONE: begin
          if (FSMIND0ACK) begin
            FSMIND0 <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          FSMIND1ACK <= 1'b0;
          FSMIND0    <= 1'b0;
          ROW_SEL    <= 1'b0;
          ADC_START  <= 1'b0;
          DOUT_VALID <= 1'b0;
          DOUT_LAST  <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_fsm.sv
module tb_readout_fsm;

  localparam int NR = 2;
  localparam int NC = 3;
  localparam int AW = 12;

  logic          CLKMPRE = 1'b0;
  logic          RESET = 1'b1;
  logic          FSMIND1 = 1'b0;
  logic          FSMIND1ACK;
  logic          FSMIND0;
  logic          FSMIND0ACK = 1'b0;
  logic [7:0]    ROW_ADDR;
  logic          ROW_SEL;
  logic          ADC_START;
  logic [15:0]   COL_ADDR;
  logic [AW-1:0] ADC_DATA;
  logic [AW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY = 1'b1;
  logic          DOUT_LAST;
  logic [8:1]    fsm_stat;
  logic [31:0]   CntFrame;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [AW-1:0] d;
    logic          l;
  } word_t;
  word_t q[$];

  int exp_d[6] = '{0, 1, 2, 16, 17, 18};
  bit exp_l[6] = '{0, 0, 0, 0, 0, 1};

  readout_fsm #(
    .C_NUM_ROWS(NR), .C_NUM_COLS(NC), .C_ADC_W(AW),
    .C_ROW_SETTLE(2), .C_ADC_CYCLES(4)
  ) dut (
    .CLKMPRE(CLKMPRE), .RESET(RESET),
    .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK),
    .ROW_ADDR(ROW_ADDR), .ROW_SEL(ROW_SEL), .ADC_START(ADC_START),
    .COL_ADDR(COL_ADDR), .ADC_DATA(ADC_DATA),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_LAST(DOUT_LAST), .fsm_stat(fsm_stat), .CntFrame(CntFrame)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  // Array model: word = column + 16 * row.
  logic [15:0] adc_sum;
  assign adc_sum  = COL_ADDR + {4'b0, ROW_ADDR, 4'b0};
  assign ADC_DATA = adc_sum[AW-1:0];

  // Capture every accepted word.
  always @(posedge CLKMPRE) begin
    if (!RESET && DOUT_VALID && DOUT_READY) begin
      word_t w;
      w.d = DOUT;
      w.l = DOUT_LAST;
      q.push_back(w);
      $display("word accepted: dout=%0d last=%0b", DOUT, DOUT_LAST);
    end
  end

  task automatic tick();
    @(posedge CLKMPRE);
    #1;
  endtask

  task automatic request(output bit to);
    FSMIND1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (FSMIND1ACK === 1'b1) break;
    end
    to = (FSMIND1ACK !== 1'b1);
    FSMIND1 = 1'b0;
  endtask

  task automatic wait_fsmind0(output bit to);
    for (int i = 0; i < 1000; i++) begin
      if (FSMIND0 === 1'b1) break;
      tick();
    end
    to = (FSMIND0 !== 1'b1);
  endtask

  task automatic give_ack0();
    FSMIND0ACK = 1'b1;
    tick();
    FSMIND0ACK = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    total++;
    if ({FSMIND1ACK, FSMIND0, ROW_SEL, ADC_START, DOUT_VALID, DOUT_LAST} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 000000",
               {FSMIND1ACK, FSMIND0, ROW_SEL, ADC_START, DOUT_VALID, DOUT_LAST});
    end
    total++;
    if ({ROW_ADDR, COL_ADDR, DOUT} !== '0) begin
      bad++;
      $display("FAIL reset_addr_data: row=%0d col=%0d dout=%0d want 0", ROW_ADDR, COL_ADDR, DOUT);
    end
    total++;
    if (fsm_stat !== 8'h01) begin
      bad++;
      $display("FAIL reset_stat: got %h want 01", fsm_stat);
    end
    total++;
    if (CntFrame !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", CntFrame);
    end
    RESET = 1'b0;
    tick();
    $display("test_reset complete");
  endtask

  task automatic test_basic_frame();
    bit to;
    DOUT_READY = 1'b1;
    q.delete();
    FSMIND1 = 1'b1;
    tick();
    total++;
    if (FSMIND1ACK !== 1'b1 || fsm_stat !== 8'h02) begin
      bad++;
      $display("FAIL basic_ack1: ack=%b stat=%h want 1/02", FSMIND1ACK, fsm_stat);
    end
    FSMIND1 = 1'b0;
    wait_fsmind0(to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL basic_timeout: FSMIND0 never rose");
    end
    total++;
    if (q.size() != 6) begin
      bad++;
      $display("FAIL basic_count: got %0d words want 6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (q[i].d !== AW'(exp_d[i]) || q[i].l !== exp_l[i]) begin
          bad++;
          $display("FAIL basic_word%0d: got %0d/%b want %0d/%b", i, q[i].d, q[i].l, exp_d[i], exp_l[i]);
        end
      end
    end
    total++;
    if (CntFrame !== 32'd1 || fsm_stat !== 8'h40) begin
      bad++;
      $display("FAIL basic_done: cnt=%0d stat=%h want 1/40", CntFrame, fsm_stat);
    end
    give_ack0();
    total++;
    if (FSMIND0 !== 1'b0 || fsm_stat !== 8'h01) begin
      bad++;
      $display("FAIL basic_idle: fsmind0=%b stat=%h want 0/01", FSMIND0, fsm_stat);
    end
    $display("test_basic_frame complete");
  endtask

  task automatic test_stall();
    bit to;
    int stalls = 0;
    logic [AW-1:0] sd;
    logic sl;
    DOUT_READY = 1'b1;
    q.delete();
    request(to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL stall_req: no FSMIND1ACK");
    end
    for (int n = 0; n < 2000 && FSMIND0 !== 1'b1; n++) begin
      DOUT_READY = ~DOUT_READY;
      if (DOUT_VALID === 1'b1 && DOUT_READY === 1'b0) begin
        sd = DOUT;
        sl = DOUT_LAST;
        tick();
        stalls++;
        total++;
        if (DOUT !== sd || DOUT_LAST !== sl || DOUT_VALID !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold: got %0d/%b/%b want %0d/%b/1", DOUT, DOUT_LAST, DOUT_VALID, sd, sl);
        end
      end else begin
        tick();
      end
    end
    DOUT_READY = 1'b1;
    total++;
    if (FSMIND0 !== 1'b1 || stalls == 0) begin
      bad++;
      $display("FAIL stall_done: fsmind0=%b stalls=%0d want 1/nonzero", FSMIND0, stalls);
    end
    total++;
    if (q.size() != 6) begin
      bad++;
      $display("FAIL stall_count: got %0d words want 6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (q[i].d !== AW'(exp_d[i]) || q[i].l !== exp_l[i]) begin
          bad++;
          $display("FAIL stall_word%0d: got %0d/%b want %0d/%b", i, q[i].d, q[i].l, exp_d[i], exp_l[i]);
        end
      end
    end
    total++;
    if (CntFrame !== 32'd2) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want 2", CntFrame);
    end
    give_ack0();
    $display("test_stall complete");
  endtask

  task automatic test_hold_req();
    bit to;
    bit rose = 1'b0;
    FSMIND1 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (FSMIND1ACK !== 1'b1 || ROW_SEL !== 1'b0) begin
        bad++;
        $display("FAIL hold_ack%0d: ack=%b rowsel=%b want 1/0", i, FSMIND1ACK, ROW_SEL);
      end
    end
    FSMIND1 = 1'b0;
    tick();
    total++;
    if (FSMIND1ACK !== 1'b0 || fsm_stat !== 8'h04) begin
      bad++;
      $display("FAIL hold_release: ack=%b stat=%h want 0/04", FSMIND1ACK, fsm_stat);
    end
    for (int i = 0; i < 10; i++) begin
      if (ROW_SEL === 1'b1) begin
        rose = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!rose) begin
      bad++;
      $display("FAIL hold_rowsel: ROW_SEL never rose");
    end
    wait_fsmind0(to);
    total++;
    if (to || CntFrame !== 32'd3) begin
      bad++;
      $display("FAIL hold_done: timeout=%b cnt=%0d want 0/3", to, CntFrame);
    end
    give_ack0();
    $display("test_hold_req complete");
  endtask

  task automatic test_timing();
    bit to;
    int n = 0;
    int m = 0;
    request(to);
    for (int i = 0; i < 20 && ROW_SEL !== 1'b1; i++) tick();
    for (int i = 0; i < 50 && ADC_START !== 1'b1; i++) begin
      tick();
      n++;
    end
    total++;
    if (n != 2 || to) begin
      bad++;
      $display("FAIL timing_settle: got %0d cycles want 2 (req timeout=%b)", n, to);
    end
    tick();
    m = 1;
    total++;
    if (ADC_START !== 1'b0) begin
      bad++;
      $display("FAIL timing_pulse: ADC_START=%b want 0", ADC_START);
    end
    for (int i = 0; i < 50 && DOUT_VALID !== 1'b1; i++) begin
      tick();
      m++;
    end
    total++;
    if (m != 5) begin
      bad++;
      $display("FAIL timing_conv: got %0d cycles want 5", m);
    end
    wait_fsmind0(to);
    total++;
    if (to || CntFrame !== 32'd4) begin
      bad++;
      $display("FAIL timing_done: timeout=%b cnt=%0d want 0/4", to, CntFrame);
    end
    give_ack0();
    $display("test_timing complete");
  endtask

  task automatic test_done_delay();
    bit to;
    request(to);
    wait_fsmind0(to);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (FSMIND0 !== 1'b1 || fsm_stat !== 8'h40) begin
        bad++;
        $display("FAIL done_hold%0d: fsmind0=%b stat=%h want 1/40", i, FSMIND0, fsm_stat);
      end
    end
    FSMIND0ACK = 1'b1;
    tick();
    FSMIND0ACK = 1'b0;
    total++;
    if (FSMIND0 !== 1'b0 || fsm_stat !== 8'h01 || CntFrame !== 32'd5) begin
      bad++;
      $display("FAIL done_release: fsmind0=%b stat=%h cnt=%0d want 0/01/5", FSMIND0, fsm_stat, CntFrame);
    end
    $display("test_done_delay complete");
  endtask

  task automatic test_midframe_reset();
    bit to;
    bit found = 1'b0;
    DOUT_READY = 1'b1;
    request(to);
    for (int i = 0; i < 200; i++) begin
      if (fsm_stat === 8'h10 && ROW_ADDR === 8'd1 && DOUT_VALID === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reach: never saw S_READ on row 1");
    end
    RESET = 1'b1;
    tick();
    total++;
    if ({FSMIND1ACK, FSMIND0, ROW_SEL, ADC_START, DOUT_VALID, DOUT_LAST} !== 6'b0 ||
        {ROW_ADDR, COL_ADDR, DOUT} !== '0 || fsm_stat !== 8'h01 || CntFrame !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: row=%0d col=%0d dout=%0d valid=%b rowsel=%b stat=%h cnt=%0d want all reset",
               ROW_ADDR, COL_ADDR, DOUT, DOUT_VALID, ROW_SEL, fsm_stat, CntFrame);
    end
    RESET = 1'b0;
    q.delete();
    tick();
    request(to);
    wait_fsmind0(to);
    total++;
    if (to || CntFrame !== 32'd1) begin
      bad++;
      $display("FAIL mid_refr: timeout=%b cnt=%0d want 0/1", to, CntFrame);
    end
    total++;
    if (q.size() != 6) begin
      bad++;
      $display("FAIL mid_count: got %0d words want 6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (q[i].d !== AW'(exp_d[i]) || q[i].l !== exp_l[i]) begin
          bad++;
          $display("FAIL mid_word%0d: got %0d/%b want %0d/%b", i, q[i].d, q[i].l, exp_d[i], exp_l[i]);
        end
      end
    end
    give_ack0();
    $display("test_midframe_reset complete");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_hold_req();
    test_timing();
    test_done_delay();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/readout_fsm.md
# readout_fsm

Readout sequencer that sits directly downstream of the exposure state machine on the CLKMPRE domain. It accepts the end-of-exposure handshake (FSMIND1/FSMIND1ACK) and walks every pixel row: row select, settle, ADC conversion, column-by-column word streaming. After the last word is accepted it hands control back to exposure through the FSMIND0/FSMIND0ACK handshake.

## Interface
Parameters:
- C_NUM_ROWS, 176, pixel rows to read per frame
- C_NUM_COLS, 244, column words per row
- C_ADC_W, 12, ADC word width
- C_ROW_SETTLE, 4, CLKMPRE cycles between ROW_SEL rising and ADC_START
- C_ADC_CYCLES, 32, CLKMPRE cycles from ADC_START to data valid

Ports:
- CLKMPRE  in  1  sole clock; all logic on the rising edge
- RESET  in  1  synchronous, active-high reset
- FSMIND1  in  1  exposure done, readout requested (level, held until ack)
- FSMIND1ACK  out  1  acknowledge of FSMIND1
- FSMIND0  out  1  readout done, exposure may restart (level, held until ack)
- FSMIND0ACK  in  1  acknowledge of FSMIND0
- ROW_ADDR  out  8  row being read, 0..C_NUM_ROWS-1
- ROW_SEL  out  1  row select to the array
- ADC_START  out  1  one-cycle conversion start pulse
- COL_ADDR  out  16  column mux select; ADC_DATA reflects it in the same cycle
- ADC_DATA  in  C_ADC_W  converted word for COL_ADDR
- DOUT  out  C_ADC_W  output word
- DOUT_VALID  out  1  DOUT holds a word
- DOUT_READY  in  1  downstream accepts DOUT when high with DOUT_VALID
- DOUT_LAST  out  1  high with the final word of the frame
- fsm_stat  out  [8:1]  state code
- CntFrame  out  32  frames completed since reset

## Operation
- States and fsm_stat codes: S_IDLE 8'h01, S_ACK1 8'h02, S_ROWSEL 8'h04, S_CONV 8'h08, S_READ 8'h10, S_ROWNEXT 8'h20, S_DONE 8'h40.
- S_IDLE: all strobes low. FSMIND1=1 -> S_ACK1, and FSMIND1ACK <= 1.
- S_ACK1: hold FSMIND1ACK=1 until FSMIND1=0. Then FSMIND1ACK <= 0, ROW_ADDR <= 0, go to S_ROWSEL.
- S_ROWSEL: ROW_SEL=1, counter runs C_ROW_SETTLE cycles. Then ADC_START pulses high for one cycle and the FSM goes to S_CONV.
- S_CONV: counter runs C_ADC_CYCLES cycles. Then COL_ADDR <= 0 and the FSM goes to S_READ.
- S_READ: an advance occurs when (!DOUT_VALID || DOUT_READY). On an advance with columns remaining:
  - DOUT <= ADC_DATA, DOUT_VALID <= 1, COL_ADDR increments.
  - DOUT_LAST <= 1 when COL_ADDR = C_NUM_COLS-1 and ROW_ADDR = C_NUM_ROWS-1.
- S_READ exit: after the last column is loaded, go to S_ROWNEXT once that word is accepted.
- S_ROWNEXT: ROW_SEL <= 0.
  - ROW_ADDR < C_NUM_ROWS-1: ROW_ADDR increments, go to S_ROWSEL.
  - Otherwise: FSMIND0 <= 1, CntFrame increments, go to S_DONE.
- S_DONE: hold FSMIND0=1 until FSMIND0ACK=1. Then FSMIND0 <= 0 and go to S_IDLE.
- FSMIND1 changes outside S_IDLE/S_ACK1 are ignored. A new request is only taken in S_IDLE.
- Any undefined state goes to S_IDLE.

## Timing
- Reset values: FSMIND1ACK=0, FSMIND0=0, ROW_ADDR=0, ROW_SEL=0, ADC_START=0, COL_ADDR=0, DOUT=0, DOUT_VALID=0, DOUT_LAST=0, fsm_stat=8'h01, CntFrame=0. State resets to S_IDLE.
- RESET mid-frame aborts immediately. Any word held on DOUT is dropped, and CntFrame does not increment.
- FSMIND1 sampled high at edge N gives FSMIND1ACK=1 after edge N.
- ADC_START is exactly C_ROW_SETTLE cycles after the ROW_SEL rise. The first DOUT_VALID is C_ADC_CYCLES+1 cycles after ADC_START.
- Back-to-back READY=1 gives one word per cycle with no bubbles inside a row.
- Row overhead is 3 + C_ROW_SETTLE + C_ADC_CYCLES cycles.
- DOUT, DOUT_VALID and DOUT_LAST hold stable while DOUT_VALID=1 and DOUT_READY=0.
- DOUT_VALID falls the cycle after the last accepted word unless the next row's word is loaded. Across rows it always falls.
- FSMIND0 rises the cycle after S_ROWNEXT on the last row, and falls the cycle after FSMIND0ACK is sampled high.
- CntFrame wraps from 2^32-1 to 0.

## Test plan
- Small config (C_NUM_ROWS=2, C_NUM_COLS=3, C_ROW_SETTLE=2, C_ADC_CYCLES=4), READY=1, ADC_DATA=COL_ADDR+16*ROW_ADDR: pulse FSMIND1 with an ack-driven release -> 6 words 0,1,2,16,17,18, DOUT_LAST only on 18, FSMIND0=1, CntFrame=1.
- Same config, DOUT_READY toggled 1/0 every cycle -> identical word sequence with no drops or duplicates, and DOUT stable during every stall.
- Hold FSMIND1 high 5 cycles after FSMIND1ACK -> FSMIND1ACK stays 1 for those 5 cycles, and ROW_SEL rises only after FSMIND1 falls.
- Delay FSMIND0ACK 10 cycles in S_DONE -> FSMIND0 high for all 10 cycles, falls one cycle after the ack, and fsm_stat returns to 8'h01.
- Assert RESET while in S_READ on row 1 -> next cycle every output is at its reset value, and a subsequent FSMIND1 gives a complete frame starting at row 0.
- Measure ROW_SEL to ADC_START to the first DOUT_VALID -> exactly 2 and 5 cycles in the small config.
